addsub_issue_stage: RTL and testbench

Operand-issue and result-capture stage for the ripple-carry `adder_subtractor`. It buffers operand triples (A, B, mode) from an upstream valid/ready source in a small FIFO and drives the head entry onto the combinational adder/subtractor. It registers the adder's `out`/`carry` together with derived flags into a result register, and presents that register to a downstream consumer over valid/ready. The block sits directly upstream of `adder_subtractor` and also owns its result register.

---
 rtl/addsub_issue_stage.sv | 98 +++++++++
 tb/tb_addsub_issue_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_issue_stage.sv
// Operand-issue FIFO and result register wrapped around an external
// combinational adder/subtractor; valid/ready on both sides.
module addsub_issue_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_mode,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_mode,
  input  logic [WIDTH-1:0]         add_out,
  input  logic                     add_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_out,
  output logic                     res_carry,
  output logic                     res_ovf,
  output logic                     res_zero,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [LW-1:0]   r_level;
  logic            r_res_valid, r_res_carry, r_res_ovf, r_res_zero;
  logic [WIDTH-1:0] r_res_out;

  logic   w_head_vld, w_push, w_load, w_ovf;
  entry_t w_head;

  // Head is gated by rst so the adder sees zeros while reset is held.
  assign w_head_vld = !rst && (r_level != '0);
  assign w_head     = w_head_vld ? r_mem[r_rd] : '0;
  assign add_a      = w_head.a;
  assign add_b      = w_head.b;
  assign add_mode   = w_head.mode;

  assign in_ready = !rst && (r_level < LW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_load   = w_head_vld && (!r_res_valid || res_ready);

  assign w_ovf = add_mode
    ? (add_a[MSB] != add_b[MSB]) && (add_out[MSB] != add_a[MSB])
    : (add_a[MSB] == add_b[MSB]) && (add_out[MSB] != add_a[MSB]);

  // Storage needs no reset: level==0 masks stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{a: in_a, b: in_b, mode: in_mode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_level     <= '0;
      r_res_valid <= 1'b0;
      r_res_out   <= '0;
      r_res_carry <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_res_zero  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_load) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_load);
      if (w_load) begin
        r_res_valid <= 1'b1;
        r_res_out   <= add_out;
        r_res_carry <= add_carry;
        r_res_ovf   <= w_ovf;
        r_res_zero  <= (add_out == '0);
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_out   = r_res_out;
  assign res_carry = r_res_carry;
  assign res_ovf   = r_res_ovf;
  assign res_zero  = r_res_zero;
  assign level     = r_level;
endmodule

// File: tb/tb_addsub_issue_stage.sv
// Directed + randomized bench for addsub_issue_stage; the adder is modelled
// here and results are checked against a queue-based reference.
module tb_addsub_issue_stage;
  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_mode = 1'b0, res_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] add_a, add_b, add_out, res_out;
  logic add_mode, add_carry, res_valid, res_carry, res_ovf, res_zero;
  logic [$clog2(D):0] level;

  always #5 clk = ~clk;

  addsub_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
    .add_out(add_out), .add_carry(add_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .res_carry(res_carry), .res_ovf(res_ovf), .res_zero(res_zero),
    .level(level)
  );

  // Ripple adder/subtractor stand-in: A + B or A + ~B + 1.
  always_comb begin
    if (add_mode) {add_carry, add_out} = {1'b0, add_a} + {1'b0, ~add_b} + 5'd1;
    else          {add_carry, add_out} = {1'b0, add_a} + {1'b0, add_b};
  end

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic m; } trip_t;
  typedef struct packed { logic [W-1:0] o; logic c; logic v; logic z; } res_t;

  int n_err = 0, n_checks = 0, n_acc = 0, n_del = 0;
  trip_t q[$];
  res_t  sb[$];
  logic  m_rv = 1'b0;
  res_t  m_res = '0;

  function automatic res_t calc(trip_t t);
    int ua, ub, sa, sb_, r, sr;
    res_t x;
    ua = int'(t.a); ub = int'(t.b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb_ = (ub >= 8) ? ub - 16 : ub;
    if (t.m) begin r = ua - ub; x.c = (ua >= ub); sr = sa - sb_; end
    else     begin r = ua + ub; x.c = (r > 15);   sr = sa + sb_; end
    x.o = W'(r & 15);
    x.v = (sr > 7) || (sr < -8);
    x.z = (x.o == 0);
    return x;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update model from pre-edge inputs, then check #1 after the edge.
  task automatic step();
    logic  p_rst, p_push, p_rdy, p_stall, do_load, pushable;
    trip_t p_in, p_add, t;
    p_rst   = rst;
    p_rdy   = res_ready;
    p_in    = '{a: in_a, b: in_b, m: in_mode};
    p_add   = '{a: add_a, b: add_b, m: add_mode};
    p_stall = !rst && res_valid && !res_ready;
    p_push  = in_valid && in_ready;
    if (!p_rst && p_push) begin n_acc++; sb.push_back(calc(p_in)); end
    if (!p_rst && res_valid && res_ready) begin
      n_del++;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_order", {res_out, res_carry, res_ovf, res_zero}, sb.pop_front());
    end
    @(posedge clk);
    if (p_rst) begin
      q.delete(); sb.delete(); m_rv = 1'b0; m_res = '0;
    end else begin
      pushable = (q.size() < D);
      do_load  = (q.size() != 0) && (!m_rv || p_rdy);
      if (do_load) begin t = q.pop_front(); m_res = calc(t); m_rv = 1'b1; end
      else if (m_rv && p_rdy) m_rv = 1'b0;
      if (in_valid && pushable) q.push_back(p_in);
    end
    #1;
    chk("res_valid", res_valid, m_rv);
    chk("res_fields", {res_out, res_carry, res_ovf, res_zero}, m_res);
    chk("level", level, q.size());
    chk("in_ready", in_ready, !rst && (q.size() < D));
    chk("add_head", {add_a, add_b, add_mode},
        (rst || q.size() == 0) ? '0 : q[0]);
    if (p_stall) chk("add_stable", {add_a, add_b, add_mode}, p_add);
  endtask

  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic m);
    in_valid = v; in_a = a; in_b = b; in_mode = m;
  endtask

  logic [W-1:0] s_a[4] = '{4'h0, 4'h9, 4'hf, 4'h1};
  logic [W-1:0] s_b[4] = '{4'h0, 4'h6, 4'ha, 4'h8};
  logic         s_m[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] e_o[4] = '{4'h0, 4'hf, 4'h5, 4'h9};
  logic         e_c[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic         e_v[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic         e_z[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int base, cyc;
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_add_a", add_a, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // a - 8: single subtract, one-cycle latency
    res_ready = 1'b1;
    drive(1, 4'ha, 4'h8, 1); step();
    drive(0, 0, 0, 0); step();
    chk("t1_valid", res_valid, 1);
    chk("t1_out", res_out, 4'h2);
    chk("t1_carry", res_carry, 1);
    chk("t1_ovf", res_ovf, 0);
    chk("t1_zero", res_zero, 0);
    step();

    // Back-to-back stream, results on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, s_a[i], s_b[i], s_m[i]); step();
      if (i > 0) chk("strm", {res_valid, res_out, res_carry, res_ovf, res_zero},
                     {1'b1, e_o[i-1], e_c[i-1], e_v[i-1], e_z[i-1]});
    end
    drive(0, 0, 0, 0); step();
    chk("strm_last", {res_valid, res_out, res_carry, res_ovf, res_zero},
        {1'b1, e_o[3], e_c[3], e_v[3], e_z[3]});
    step(); step();

    // Back-pressure: DEPTH+1 absorbed
    res_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(1, W'(i + 3), W'(2 * i + 1), i[0]); step();
    end
    drive(0, 0, 0, 0);
    chk("bp_accepted", n_acc - base, 5);
    chk("bp_level", level, 4);
    chk("bp_in_ready", in_ready, 0);
    base = n_del;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("bp_drain_count", n_del - base, 5);
    step(); step();
    chk("bp_no_dup", n_del - base, 5);

    // Add overflow and carry wrap
    drive(1, 4'h7, 4'h1, 0); step();
    drive(1, 4'hf, 4'h1, 0); step();
    chk("ovf_7p1", {res_out, res_carry, res_ovf, res_zero}, {4'h8, 1'b0, 1'b1, 1'b0});
    drive(0, 0, 0, 0); step();
    chk("wrap_fp1", {res_out, res_carry, res_ovf, res_zero}, {4'h0, 1'b1, 1'b0, 1'b1});
    step();

    // Random traffic with toggling res_ready
    base = n_acc; cyc = 0;
    while ((n_acc - base) < 20 && cyc < 400) begin
      drive(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom));
      res_ready = 1'($urandom);
      step(); cyc++;
    end
    chk("rand_accepted", n_acc - base, 20);
    drive(0, 0, 0, 0); res_ready = 1'b1;
    for (int i = 0; i < D + 2; i++) step();
    chk("rand_drained", {res_valid, level}, 0);
    chk("rand_sb_empty", sb.size(), 0);

    // Reset with entries queued and a pending result
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1, W'(i + 1), 4'h2, 0); step(); end
    drive(0, 0, 0, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_valid", res_valid, 1);
    rst = 1'b1; step();
    rst = 1'b0; #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    base = n_del; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("no_stale", n_del - base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
